// File: rtl/ps2_scancode_rx_pkg.sv
// Shared constants and types for the PS/2 scancode receiver: frame layout,
// prefix bytes, key-event layout and frame FSM encoding.
package ps2_scancode_rx_pkg;

  localparam int          FRAME_BITS = 11;
  localparam logic [7:0]  PS2_EXT    = 8'hE0;
  localparam logic [7:0]  PS2_BRK    = 8'hF0;
  localparam int          EVT_W      = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  // Event layout {ext, brk, code[7:0]}, ext in bit 9 and brk in bit 8.
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

  // Odd parity: the data bits plus the parity bit hold an odd number of ones.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Key-event stream from the receiver FIFO to the display/game logic.
interface ps2_scancode_rx_if;
  // Handshake: the head event transfers on every cycle with key_valid && key_ready.
  // key_valid never depends on key_ready; key_ready while key_valid is low has no
  // effect. key_code/key_ext/key_brk are meaningful only while key_valid is high.
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_brk;

  modport master (
    output key_valid,
    output key_code,
    output key_ext,
    output key_brk,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  key_ext,
    input  key_brk,
    output key_ready
  );
endinterface

// File: rtl/ps2_scancode_rx_sync_fifo.sv
// First-word-fall-through FIFO with occupancy count; the head output keeps the
// last popped word while the FIFO is empty.
module ps2_scancode_rx_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] hold_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  assign data_o  = empty_o ? hold_q : mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        hold_q   <= mem_q[rd_ptr_q];
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronise and filter the lines, deframe 11-bit frames,
// fold E0/F0 prefixes into key events and queue them for the consumer.
module ps2_scancode_rx
  import ps2_scancode_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          PS2Clk,
  input  logic                          PS2Data,
  output logic                          strobe,
  output logic [7:0]                    raw_byte,
  ps2_scancode_rx_if.master             key_if,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_parity,
  output logic                          err_frame,
  output logic                          overflow,
  input  logic                          clr_err,
  output frame_state_e                  frame_state
);

  localparam int         FW            = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int         TW            = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0] LAST_DATA_BIT = 3'(FRAME_BITS - 4);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic [1:0]             line_raw;
  logic [1:0]             line_filt_q;
  logic [FW-1:0]          flt_cnt_q [2];
  logic                   clk_prev_q;
  logic                   fall_edge;
  logic                   ps2_bit;

  frame_state_e           state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [TW-1:0]          tmo_cnt_q;
  logic                   good_byte;
  logic                   bad_parity;
  logic                   bad_frame;

  logic                   strobe_q;
  logic [7:0]             raw_q;
  logic                   ext_pend_q, ext_pend_d;
  logic                   brk_pend_q, brk_pend_d;
  logic                   push;
  key_evt_t               push_evt;
  key_evt_t               head_evt;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;

  logic                   err_par_q, err_par_d;
  logic                   err_frm_q, err_frm_d;
  logic                   ovf_q, ovf_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], PS2Clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], PS2Data};
    end
  end

  // Index 0 is the clock line, index 1 the data line; both get the same delay so
  // data stays aligned with the clock edge that samples it.
  assign line_raw = {data_sync_q[SYNC_STAGES-1], clk_sync_q[SYNC_STAGES-1]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      line_filt_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        flt_cnt_q[i] <= '0;
      end
    end else begin
      clk_prev_q <= line_filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (line_raw[i] == line_filt_q[i]) begin
          flt_cnt_q[i] <= '0;
        end else if (flt_cnt_q[i] == FW'(FILTER_LEN - 1)) begin
          line_filt_q[i] <= line_raw[i];
          flt_cnt_q[i]   <= '0;
        end else begin
          flt_cnt_q[i] <= flt_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign fall_edge = clk_prev_q & ~line_filt_q[0];
  assign ps2_bit   = line_filt_q[1];

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    good_byte  = 1'b0;
    bad_parity = 1'b0;
    bad_frame  = 1'b0;
    if ((state_q != ST_IDLE) && (tmo_cnt_q == TW'(TIMEOUT_CYC))) begin
      state_d   = ST_IDLE;
      bad_frame = 1'b1;
    end else if (fall_edge) begin
      case (state_q)
        ST_IDLE: begin
          // A high "start bit" is treated as line noise, not a framing error.
          if (!ps2_bit) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {ps2_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_DATA_BIT) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          par_d   = ps2_bit;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!ps2_bit) begin
            bad_frame = 1'b1;
          end else if (parity_ok(shift_q, par_q)) begin
            good_byte = 1'b1;
          end else begin
            bad_parity = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      if (fall_edge) begin
        tmo_cnt_q <= '0;
      end else if (tmo_cnt_q != TW'(TIMEOUT_CYC)) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
    end
  end

  // Prefix decoder runs one cycle after the good byte, off the registered raw byte.
  always_comb begin
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    push       = 1'b0;
    if (strobe_q) begin
      if (raw_q == PS2_EXT) begin
        ext_pend_d = 1'b1;
      end else if (raw_q == PS2_BRK) begin
        brk_pend_d = 1'b1;
      end else begin
        push       = 1'b1;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end
    if (bad_frame || bad_parity) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end
  end

  assign push_evt = '{ext: ext_pend_q, brk: brk_pend_q, code: raw_q};
  assign pop      = key_if.key_ready & ~fifo_empty;

  // Sticky flags: a set in the same cycle as clr_err wins.
  always_comb begin
    err_par_d = bad_parity | (err_par_q & ~clr_err);
    err_frm_d = bad_frame  | (err_frm_q & ~clr_err);
    ovf_d     = (push & fifo_full & ~pop) | (ovf_q & ~clr_err);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      strobe_q   <= 1'b0;
      raw_q      <= '0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      err_par_q  <= 1'b0;
      err_frm_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      strobe_q   <= good_byte;
      if (good_byte) begin
        raw_q <= shift_q;
      end
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      err_par_q  <= err_par_d;
      err_frm_q  <= err_frm_d;
      ovf_q      <= ovf_d;
    end
  end

  ps2_scancode_rx_sync_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push),
    .data_i  (push_evt),
    .pop_i   (pop),
    .data_o  (head_evt),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign strobe           = strobe_q;
  assign raw_byte         = raw_q;
  assign err_parity       = err_par_q;
  assign err_frame        = err_frm_q;
  assign overflow         = ovf_q;
  assign frame_state      = state_q;
  assign key_if.key_valid = ~fifo_empty;
  assign key_if.key_code  = head_evt.code;
  assign key_if.key_ext   = head_evt.ext;
  assign key_if.key_brk   = head_evt.brk;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: table of frames with expected events/flags, plus
// hand-written sequences for latency, timeout, FIFO full and mid-frame reset.
module tb_ps2_scancode_rx;
  import ps2_scancode_rx_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 300;
  localparam int FIFO_DEPTH  = 8;
  localparam int HALF        = 20;
  localparam int CW          = $clog2(FIFO_DEPTH) + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           ps2_clk;
  logic           ps2_data;
  logic           strobe;
  logic [7:0]     raw_byte;
  logic [CW-1:0]  fifo_count;
  logic           err_parity;
  logic           err_frame;
  logic           overflow;
  logic           clr_err;
  frame_state_e   frame_state;

  ps2_scancode_rx_if key_if();

  ps2_scancode_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .PS2Clk      (ps2_clk),
    .PS2Data     (ps2_data),
    .strobe      (strobe),
    .raw_byte    (raw_byte),
    .key_if      (key_if),
    .fifo_count  (fifo_count),
    .err_parity  (err_parity),
    .err_frame   (err_frame),
    .overflow    (overflow),
    .clr_err     (clr_err),
    .frame_state (frame_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [9:0] exp_q[$];
  logic [7:0] exp_raw_q[$];
  logic       strobe_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got no/extra DUT activity, expected the opposite", name);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      strobe_prev = 1'b0;
    end else begin
      if (strobe) begin
        if (exp_raw_q.size() == 0) fail_now("unexpected_strobe");
        else check("raw_byte", 32'(raw_byte), 32'(exp_raw_q.pop_front()));
        check("strobe_single_cycle", 32'(strobe_prev), 32'd0);
      end
      if (key_if.key_valid && key_if.key_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_event");
        else check("event", 32'({key_if.key_ext, key_if.key_brk, key_if.key_code}),
                   32'(exp_q.pop_front()));
      end
      strobe_prev = strobe;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_send_bit(input logic v);
    ps2_data = v;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop_v);
    logic par;
    par = (~^b) ^ flip_par;
    ps2_send_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_send_bit(b[i]);
    ps2_send_bit(par);
    ps2_send_bit(stop_v);
    ps2_data = 1'b1;
    cyc(2 * HALF);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
  endtask

  task automatic wait_strobe(input int budget, output logic found);
    found = 1'b0;
    for (int k = 0; k < budget; k++) begin
      cyc(1);
      if (strobe) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] b;
    logic       flip;
    logic       stop;
    logic       clr;
    logic       has_evt;
    logic [9:0] evt;
    logic       perr;
    logic       ferr;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic       found;
    logic       seen;
    logic [7:0] pb;

    vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, {2'b00, 8'h1C}, 1'b0, 1'b0};
    vecs[1]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000,        1'b0, 1'b0};
    vecs[2]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, {2'b01, 8'h1C}, 1'b0, 1'b0};
    vecs[3]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000,        1'b0, 1'b0};
    vecs[4]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000,        1'b0, 1'b0};
    vecs[5]  = '{8'h75, 1'b0, 1'b1, 1'b0, 1'b1, {2'b11, 8'h75}, 1'b0, 1'b0};
    vecs[6]  = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000,        1'b1, 1'b0};
    vecs[7]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000,        1'b1, 1'b0};
    vecs[8]  = '{8'h75, 1'b0, 1'b1, 1'b0, 1'b1, {2'b10, 8'h75}, 1'b1, 1'b0};
    vecs[9]  = '{8'hE0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000,        1'b0, 1'b0};
    vecs[10] = '{8'h6B, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000,        1'b0, 1'b1};
    vecs[11] = '{8'h6B, 1'b0, 1'b1, 1'b0, 1'b1, {2'b00, 8'h6B}, 1'b0, 1'b1};
    vecs[12] = '{8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000,        1'b0, 1'b0};
    vecs[13] = '{8'hE1, 1'b0, 1'b1, 1'b0, 1'b1, {2'b01, 8'hE1}, 1'b0, 1'b0};
    vecs[14] = '{8'hAA, 1'b0, 1'b1, 1'b0, 1'b1, {2'b00, 8'hAA}, 1'b0, 1'b0};
    vecs[15] = '{8'hFA, 1'b0, 1'b1, 1'b0, 1'b1, {2'b00, 8'hFA}, 1'b0, 1'b0};

    // ---------------- reset ----------------
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    clr_err = 1'b0;
    key_if.key_ready = 1'b0;
    cyc(5);
    check("rst_strobe",   32'(strobe),           32'd0);
    check("rst_raw_byte", 32'(raw_byte),         32'd0);
    check("rst_valid",    32'(key_if.key_valid), 32'd0);
    check("rst_count",    32'(fifo_count),       32'd0);
    check("rst_errs",     32'({err_parity, err_frame, overflow}), 32'd0);
    check("rst_state",    32'(frame_state),      32'(ST_IDLE));
    rst = 1'b0;
    cyc(5);

    // ---------------- first frame latency ----------------
    exp_raw_q.push_back(8'h1C);
    exp_q.push_back({2'b00, 8'h1C});
    fork
      send_frame(8'h1C, 1'b0, 1'b1);
      begin
        wait_strobe(2000, found);
        if (!found) fail_now("t1_strobe_timeout");
        else begin
          check("t1_raw_byte",  32'(raw_byte),          32'h1C);
          check("t1_valid_s1",  32'(key_if.key_valid),  32'd0);
          cyc(1);
          check("t1_valid_s2",  32'(key_if.key_valid),  32'd1);
          check("t1_strobe_lo", 32'(strobe),            32'd0);
          check("t1_count",     32'(fifo_count),        32'd1);
          check("t1_head", 32'({key_if.key_ext, key_if.key_brk, key_if.key_code}), 32'h01C);
        end
      end
    join
    key_if.key_ready = 1'b1;
    cyc(5);
    check("t1_drained", 32'(exp_q.size()), 32'd0);

    // ---------------- table-driven frames ----------------
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].clr) pulse_clr();
      if (!vecs[i].flip && vecs[i].stop) exp_raw_q.push_back(vecs[i].b);
      if (vecs[i].has_evt) exp_q.push_back(vecs[i].evt);
      send_frame(vecs[i].b, vecs[i].flip, vecs[i].stop);
      check($sformatf("v%0d_err_parity", i), 32'(err_parity), 32'(vecs[i].perr));
      check($sformatf("v%0d_err_frame", i),  32'(err_frame),  32'(vecs[i].ferr));
      check($sformatf("v%0d_evt_left", i),   32'(exp_q.size()), 32'd0);
      check($sformatf("v%0d_raw_left", i),   32'(exp_raw_q.size()), 32'd0);
      check($sformatf("v%0d_count", i),      32'(fifo_count), 32'd0);
    end

    // ---------------- set beats clear ----------------
    pulse_clr();
    clr_err = 1'b1;
    seen = 1'b0;
    fork
      send_frame(8'h1C, 1'b1, 1'b1);
      begin
        for (int k = 0; k < 600; k++) begin
          cyc(1);
          if (err_parity) seen = 1'b1;
        end
      end
    join
    clr_err = 1'b0;
    check("set_beats_clr", 32'(seen),       32'd1);
    check("clr_held",      32'(err_parity), 32'd0);

    // ---------------- timeout ----------------
    pulse_clr();
    pb = 8'h29;
    ps2_send_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_send_bit(pb[i]);
    ps2_data = 1'b1;
    check("to_state_data", 32'(frame_state), 32'(ST_DATA));
    cyc(TIMEOUT_CYC / 2);
    check("to_not_early", 32'(err_frame), 32'd0);
    cyc(TIMEOUT_CYC / 2 + 30);
    check("to_err_frame",  32'(err_frame),   32'd1);
    check("to_state_idle", 32'(frame_state), 32'(ST_IDLE));
    check("to_no_strobe",  32'(exp_raw_q.size()), 32'd0);
    exp_raw_q.push_back(8'h29);
    exp_q.push_back({2'b00, 8'h29});
    send_frame(8'h29, 1'b0, 1'b1);
    check("to_next_evt",     32'(exp_q.size()), 32'd0);
    check("to_frame_sticky", 32'(err_frame),    32'd1);
    pulse_clr();
    check("to_clr", 32'(err_frame), 32'd0);

    // ---------------- FIFO full / overflow ----------------
    key_if.key_ready = 1'b0;
    for (int i = 0; i <= FIFO_DEPTH; i++) begin
      pb = 8'h10 + 8'(i);
      exp_raw_q.push_back(pb);
      if (i < FIFO_DEPTH) exp_q.push_back({2'b00, pb});
      send_frame(pb, 1'b0, 1'b1);
    end
    check("ff_count",    32'(fifo_count),       32'(FIFO_DEPTH));
    check("ff_overflow", 32'(overflow),         32'd1);
    check("ff_valid",    32'(key_if.key_valid), 32'd1);
    check("ff_head",     32'(key_if.key_code),  32'h10);
    exp_raw_q.push_back(8'h40);
    exp_q.push_back({2'b00, 8'h40});
    fork
      send_frame(8'h40, 1'b0, 1'b1);
      begin
        wait_strobe(2000, found);
        if (!found) fail_now("ff_strobe_timeout");
        key_if.key_ready = 1'b1;
        cyc(1);
        key_if.key_ready = 1'b0;
      end
    join
    check("ff_pushpop_count", 32'(fifo_count),      32'(FIFO_DEPTH));
    check("ff_pushpop_head",  32'(key_if.key_code), 32'h11);
    pulse_clr();
    check("ff_ovf_clr", 32'(overflow), 32'd0);
    key_if.key_ready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) cyc(1);
    cyc(2);
    check("ff_drained",   32'(exp_q.size()),     32'd0);
    check("ff_count0",    32'(fifo_count),       32'd0);
    check("ff_valid0",    32'(key_if.key_valid), 32'd0);
    check("ff_head_hold", 32'(key_if.key_code),  32'h40);

    // ---------------- reset mid-frame ----------------
    key_if.key_ready = 1'b0;
    send_frame(8'h12, 1'b1, 1'b1);
    exp_raw_q.push_back(8'h33);
    exp_q.push_back({2'b00, 8'h33});
    send_frame(8'h33, 1'b0, 1'b1);
    exp_raw_q.push_back(8'hE0);
    send_frame(8'hE0, 1'b0, 1'b1);
    check("mr_pre_count", 32'(fifo_count), 32'd1);
    check("mr_pre_perr",  32'(err_parity), 32'd1);
    pb = 8'h5A;
    ps2_send_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_send_bit(pb[i]);
    ps2_data = 1'b1;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    exp_q.delete();
    check("mr_strobe", 32'(strobe),            32'd0);
    check("mr_raw",    32'(raw_byte),          32'd0);
    check("mr_valid",  32'(key_if.key_valid),  32'd0);
    check("mr_head",   32'({key_if.key_ext, key_if.key_brk, key_if.key_code}), 32'd0);
    check("mr_count",  32'(fifo_count),        32'd0);
    check("mr_errs",   32'({err_parity, err_frame, overflow}), 32'd0);
    check("mr_state",  32'(frame_state),       32'(ST_IDLE));
    cyc(2 * HALF);
    key_if.key_ready = 1'b1;
    exp_raw_q.push_back(8'h1C);
    exp_q.push_back({2'b00, 8'h1C});
    send_frame(8'h1C, 1'b0, 1'b1);
    check("mr_next_evt",  32'(exp_q.size()),     32'd0);
    check("mr_next_raw",  32'(exp_raw_q.size()), 32'd0);
    check("mr_next_errs", 32'({err_parity, err_frame}), 32'd0);

    cyc(10);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
